// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the Chun-Yi player sprite logic.
//   dir_t          : direction encoding (UP/DOWN/LEFT/RIGHT)
//   motion_state_t : player motion FSM states (IDLE/WALK)
//   COL_*          : bit positions inside the 4-bit wall collision vector
//   TILE           : sprite/tile edge length in pixels
//   col_bit()      : collision bit that guards a move in a given direction
//   on_grid()      : true when a coordinate sits on the tile grid
// ---------------------------------------------------------------------------
package game_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic {
      IDLE = 1'b0,
      WALK = 1'b1
   } motion_state_t;

   localparam int COL_LEFT  = 0;
   localparam int COL_RIGHT = 1;
   localparam int COL_DOWN  = 2;
   localparam int COL_UP    = 3;

   localparam int unsigned TILE = 20;

   function automatic logic [1:0] col_bit(input dir_t d);
      logic [1:0] idx;
      case (d)
         UP:      idx = 2'(COL_UP);
         DOWN:    idx = 2'(COL_DOWN);
         LEFT:    idx = 2'(COL_LEFT);
         RIGHT:   idx = 2'(COL_RIGHT);
         default: idx = 2'(COL_LEFT);
      endcase
      return idx;
   endfunction

   function automatic logic on_grid(input logic [9:0] pos);
      return ((pos % 10'(TILE)) == 10'd0);
   endfunction

endpackage

// File: rtl/player_motion_step_ticker.sv
// ---------------------------------------------------------------------------
// step_ticker
// Free-running modulo-STEP_DIV counter. tick is high for the single cycle in
// which the count equals STEP_DIV-1; the count only returns to 0 on reset or
// on its natural wrap.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset (count cleared to 0)
//   tick : high during the last cycle of each STEP_DIV period
// ---------------------------------------------------------------------------
module step_ticker #(
   parameter int STEP_DIV = 250000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            CW   = $clog2(STEP_DIV);
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: wrap to zero after the last count of the period
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/player_motion.sv
// ---------------------------------------------------------------------------
// player_motion
// Registered position controller for the player sprite. Held direction keys
// become one-pixel steps, at most one per STEP_DIV cycles, refused when the
// wall detectors flag the move or when it would leave the playfield.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   key_up/down/left/right        : debounced, clk-synchronous key levels
//   collision[3:0]                : OR of wall detectors for the current
//                                   position (bit0 L, bit1 R, bit2 D, bit3 U)
//   pos_h[9:0], pos_v[9:0]        : registered sprite position (top-left)
//   facing[1:0]                   : last requested direction (dir_t)
//   moving                        : high while the FSM is in WALK
//   step                          : one-cycle pulse after a position change
//   bump                          : one-cycle pulse after a refused step
// Build option:
//   PLAYER_GRID_SNAP_EN : once walking, keep stepping in the latched
//                         direction until both coordinates are on the
//                         20-pixel grid (a refused step ends the snap).
// ---------------------------------------------------------------------------
module player_motion
   import game_pkg::*;
#(
   parameter int H_INIT   = 300,
   parameter int V_INIT   = 220,
   parameter int H_MAX    = 620,
   parameter int V_MAX    = 460,
   parameter int STEP_DIV = 250000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   input  logic [3:0] collision,
   output logic [9:0] pos_h,
   output logic [9:0] pos_v,
   output logic [1:0] facing,
   output logic       moving,
   output logic       step,
   output logic       bump
);

   localparam logic [9:0] H_INIT_C = 10'(H_INIT);
   localparam logic [9:0] V_INIT_C = 10'(V_INIT);
   localparam logic [9:0] H_MAX_C  = 10'(H_MAX);
   localparam logic [9:0] V_MAX_C  = 10'(V_MAX);

   logic          tick_s;
   motion_state_t state_q, state_d;
   logic [9:0]    pos_h_q, pos_h_d;
   logic [9:0]    pos_v_q, pos_v_d;
   dir_t          facing_q, facing_d;
   logic          step_q, step_d;
   logic          bump_q, bump_d;

   logic          req_valid_s;
   dir_t          req_dir_s;
   logic          snap_hold_s;
   dir_t          move_dir_s;
   logic          at_edge_s;
   logic          blocked_s;
   logic [9:0]    h_next_s;
   logic [9:0]    v_next_s;

   step_ticker #(
      .STEP_DIV (STEP_DIV)
   ) u_step_ticker (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_s)
   );

   // Fixed-priority key arbitration: up > down > left > right
   always_comb begin
      req_valid_s = 1'b1;
      req_dir_s   = DOWN;
      if (key_up) begin
         req_dir_s = UP;
      end else if (key_down) begin
         req_dir_s = DOWN;
      end else if (key_left) begin
         req_dir_s = LEFT;
      end else if (key_right) begin
         req_dir_s = RIGHT;
      end else begin
         req_valid_s = 1'b0;
      end
   end

`ifdef PLAYER_GRID_SNAP_EN
   logic snap_brk_q, snap_brk_d;
   logic aligned_s;

   assign aligned_s   = on_grid(pos_h_q) && on_grid(pos_v_q);
   // While unaligned in WALK the keys are ignored unless a refusal broke the snap
   assign snap_hold_s = (state_q == WALK) && !aligned_s && !snap_brk_q;

   // A refused step hands control back to the keys until the grid or IDLE is reached
   always_comb begin
      snap_brk_d = snap_brk_q;
      if (tick_s) begin
         if (snap_hold_s && blocked_s) begin
            snap_brk_d = 1'b1;
         end else if (aligned_s || (state_d == IDLE)) begin
            snap_brk_d = 1'b0;
         end else begin
            snap_brk_d = snap_brk_q;
         end
      end else begin
         snap_brk_d = snap_brk_q;
      end
   end

   // Snap-break flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_brk_q <= 1'b0;
      end else begin
         snap_brk_q <= snap_brk_d;
      end
   end
`else
   assign snap_hold_s = 1'b0;
`endif

   // During a snap the latched direction replaces the arbitrated one
   assign move_dir_s = snap_hold_s ? facing_q : req_dir_s;

   // Playfield edge check and candidate position for the attempted direction
   always_comb begin
      at_edge_s = 1'b0;
      h_next_s  = pos_h_q;
      v_next_s  = pos_v_q;
      case (move_dir_s)
         UP: begin
            at_edge_s = (pos_v_q == 10'd0);
            v_next_s  = pos_v_q - 10'd1;
         end
         DOWN: begin
            at_edge_s = (pos_v_q == V_MAX_C);
            v_next_s  = pos_v_q + 10'd1;
         end
         LEFT: begin
            at_edge_s = (pos_h_q == 10'd0);
            h_next_s  = pos_h_q - 10'd1;
         end
         RIGHT: begin
            at_edge_s = (pos_h_q == H_MAX_C);
            h_next_s  = pos_h_q + 10'd1;
         end
         default: begin
            at_edge_s = 1'b1;
         end
      endcase
   end

   assign blocked_s = at_edge_s | collision[col_bit(move_dir_s)];

   // Motion FSM next state, position update and pulse generation
   always_comb begin
      state_d  = state_q;
      pos_h_d  = pos_h_q;
      pos_v_d  = pos_v_q;
      facing_d = facing_q;
      step_d   = 1'b0;
      bump_d   = 1'b0;
      if (tick_s) begin
         case (state_q)
            IDLE, WALK: begin
               // Release takes precedence over any collision on the same tick
               if (req_valid_s || snap_hold_s) begin
                  state_d  = WALK;
                  facing_d = move_dir_s;
                  if (blocked_s) begin
                     bump_d = 1'b1;
                  end else begin
                     pos_h_d = h_next_s;
                     pos_v_d = v_next_s;
                     step_d  = 1'b1;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State, position and pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         pos_h_q  <= H_INIT_C;
         pos_v_q  <= V_INIT_C;
         facing_q <= DOWN;
         step_q   <= 1'b0;
         bump_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pos_h_q  <= pos_h_d;
         pos_v_q  <= pos_v_d;
         facing_q <= facing_d;
         step_q   <= step_d;
         bump_q   <= bump_d;
      end
   end

   assign pos_h  = pos_h_q;
   assign pos_v  = pos_v_q;
   assign facing = facing_q;
   assign moving = (state_q == WALK);
   assign step   = step_q;
   assign bump   = bump_q;

endmodule

// File: tb/tb_player_motion.sv
// ---------------------------------------------------------------------------
// tb_player_motion
// Directed self-checking bench for player_motion with STEP_DIV = 4.
// Expected output tuples are queued when a tick's stimulus is applied and
// popped at the clock edge that ends that tick; the three cycles between
// ticks must hold the previous position with step/bump low.
// ---------------------------------------------------------------------------
module tb_player_motion;
   import game_pkg::*;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic [1:0] f;
      logic       mv;
      logic       st;
      logic       bp;
   } obs_t;

   logic       clk;
   logic       rst;
   logic       key_up, key_down, key_left, key_right;
   logic [3:0] collision;
   logic [9:0] pos_h, pos_v;
   logic [1:0] facing;
   logic       moving, step, bump;

   obs_t exp_q[$];
   obs_t cur_exp;
   int   vectors;
   int   miscompares;

   player_motion #(
      .H_INIT   (300),
      .V_INIT   (220),
      .H_MAX    (620),
      .V_MAX    (460),
      .STEP_DIV (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_up    (key_up),
      .key_down  (key_down),
      .key_left  (key_left),
      .key_right (key_right),
      .collision (collision),
      .pos_h     (pos_h),
      .pos_v     (pos_v),
      .facing    (facing),
      .moving    (moving),
      .step      (step),
      .bump      (bump)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t mk(input int h, input int v, input dir_t f,
                               input logic mv, input logic st, input logic bp);
      obs_t e;
      e.h  = 10'(h);
      e.v  = 10'(v);
      e.f  = f;
      e.mv = mv;
      e.st = st;
      e.bp = bp;
      return e;
   endfunction

   task automatic compare(input string tag, input obs_t exp);
      obs_t got;
      got = {pos_h, pos_v, facing, moving, step, bump};
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed h=%0d v=%0d facing=%0d moving=%0b step=%0b bump=%0b, expected h=%0d v=%0d facing=%0d moving=%0b step=%0b bump=%0b",
                tag, got.h, got.v, got.f, got.mv, got.st, got.bp,
                exp.h, exp.v, exp.f, exp.mv, exp.st, exp.bp);
      end
   endtask

   // One step period: three quiet cycles, then the tick edge
   task automatic do_tick(input string tag, input int h, input int v, input dir_t f,
                          input logic mv, input logic st, input logic bp);
      obs_t quiet;
      obs_t e;
      exp_q.push_back(mk(h, v, f, mv, st, bp));
      quiet    = cur_exp;
      quiet.st = 1'b0;
      quiet.bp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         compare({tag, "/gap"}, quiet);
      end
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      compare(tag, e);
      cur_exp = e;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      key_up      = 1'b0;
      key_down    = 1'b0;
      key_left    = 1'b0;
      key_right   = 1'b0;
      collision   = 4'b0000;

      @(posedge clk);
      #1;
      cur_exp = mk(300, 220, DOWN, 1'b0, 1'b0, 1'b0);
      compare("reset", cur_exp);
      rst = 1'b0;

      // no keys: nothing moves, no pulses
      for (int i = 0; i < 10; i++) do_tick("idle", 300, 220, DOWN, 1'b0, 1'b0, 1'b0);

`ifdef PLAYER_GRID_SNAP_EN
      // one-tick tap keeps walking until the 20-pixel grid is reached
      key_right = 1'b1;
      do_tick("snap_go", 301, 220, RIGHT, 1'b1, 1'b1, 1'b0);
      key_right = 1'b0;
      for (int i = 2; i <= 20; i++) do_tick("snap_run", 300 + i, 220, RIGHT, 1'b1, 1'b1, 1'b0);
      do_tick("snap_stop", 320, 220, RIGHT, 1'b0, 1'b0, 1'b0);
      do_tick("snap_idle", 320, 220, RIGHT, 1'b0, 1'b0, 1'b0);
`else
      // free walk right for five ticks, then release
      key_right = 1'b1;
      for (int i = 1; i <= 5; i++) do_tick("right", 300 + i, 220, RIGHT, 1'b1, 1'b1, 1'b0);
      key_right = 1'b0;
      do_tick("right_release", 305, 220, RIGHT, 1'b0, 1'b0, 1'b0);

      // left blocked by wall: bump every tick
      key_left  = 1'b1;
      collision = 4'b0001;
      for (int i = 0; i < 3; i++) do_tick("left_blocked", 305, 220, LEFT, 1'b1, 1'b0, 1'b1);
      // release and collision on the same tick: release wins
      key_left = 1'b0;
      do_tick("release_vs_col", 305, 220, LEFT, 1'b0, 1'b0, 1'b0);

      // only the bit for the requested direction blocks
      key_right = 1'b1;
      collision = 4'b1101;
      do_tick("right_other_cols", 306, 220, RIGHT, 1'b1, 1'b1, 1'b0);
      do_tick("right_other_cols", 307, 220, RIGHT, 1'b1, 1'b1, 1'b0);

      // direction change while walking
      key_right = 1'b0;
      collision = 4'b0000;
      key_left  = 1'b1;
      for (int i = 1; i <= 7; i++) do_tick("left", 307 - i, 220, LEFT, 1'b1, 1'b1, 1'b0);
      key_left = 1'b0;
      key_up   = 1'b1;
      for (int i = 1; i <= 219; i++) do_tick("up", 300, 220 - i, UP, 1'b1, 1'b1, 1'b0);

      // up+left at v=1: up wins, reaches 0, then the top edge refuses
      key_left = 1'b1;
      do_tick("up_left_edge", 300, 0, UP, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) do_tick("top_bump", 300, 0, UP, 1'b1, 1'b0, 1'b1);
      key_up   = 1'b0;
      key_left = 1'b0;
      do_tick("top_release", 300, 0, UP, 1'b0, 1'b0, 1'b0);

      // walk to (310,220) then reset between clock edges
      rst = 1'b1;
      #1;
      cur_exp = mk(300, 220, DOWN, 1'b0, 1'b0, 1'b0);
      compare("reset2", cur_exp);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      key_right = 1'b1;
      for (int i = 1; i <= 10; i++) do_tick("walk310", 300 + i, 220, RIGHT, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      cur_exp = mk(300, 220, DOWN, 1'b0, 1'b0, 1'b0);
      compare("async_reset", cur_exp);
      key_right = 1'b0;
      @(posedge clk);
      #1;
      compare("reset_hold", cur_exp);
      rst = 1'b0;

      // tick counter restarted from 0: first tick lands four edges later
      key_down  = 1'b1;
      collision = 4'b0100;
      do_tick("down_blocked", 300, 220, DOWN, 1'b1, 1'b0, 1'b1);
      collision = 4'b0000;
      do_tick("down", 300, 221, DOWN, 1'b1, 1'b1, 1'b0);
      key_down = 1'b0;
      do_tick("down_release", 300, 221, DOWN, 1'b0, 1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/player_motion.md
# player_motion

Registered position controller for the Chun-Yi player sprite. It consumes the 4-bit collision flags from the wall collision detectors, which are OR-reduced across all walls, and turns the held direction keys into one-pixel steps at a fixed rate. Its `pos_h`/`pos_v` outputs feed the wall detectors, the renderer and the game logic as the authoritative player position.

## Interface

Parameters:
- `H_INIT`, default 300: reset horizontal position, in pixels (left edge of sprite).
- `V_INIT`, default 220: reset vertical position, in pixels (top edge).
- `H_MAX`, default 620: largest legal `pos_h`. The minimum is 0.
- `V_MAX`, default 460: largest legal `pos_v`. The minimum is 0.
- `STEP_DIV`, default 250000: clock cycles per step tick. Legal range is 2 or more.

Ports (clock and reset first):
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `key_up`, `key_down`, `key_left`, `key_right`, input, 1 each: level-sensitive, already debounced and synchronous to `clk`.
- `collision`, input, 4: OR of all wall detector outputs, computed combinationally from the current `pos_h`/`pos_v`.
  - bit0: left move blocked.
  - bit1: right move blocked.
  - bit2: down move blocked.
  - bit3: up move blocked.
- `pos_h`, output, 10: player horizontal position, registered.
- `pos_v`, output, 10: player vertical position, registered.
- `facing`, output, 2: last requested direction, registered.
- `moving`, output, 1: high while the FSM is in WALK.
- `step`, output, 1: one-cycle pulse on each cycle in which the position changed.
- `bump`, output, 1: one-cycle pulse when a step tick was refused by a collision or a boundary.

## Operation

- **Tick counter:**
  - Counts from 0 to STEP_DIV-1 and wraps.
  - "Tick" is the cycle in which the count equals STEP_DIV-1.
  - The counter runs freely and is cleared only by reset.
- **Key arbitration:** when several keys are held, priority is up > down > left > right. The winning key is the request direction `req`. No key held means no request.
- **FSM states:** IDLE and WALK.
  - IDLE → WALK: on any tick with a request. The same tick also attempts the step.
  - WALK → IDLE: on a tick with no request. No step is taken on that tick.
  - WALK, tick with a request: `facing` is set to `req` and a step is attempted in `req`. The direction may change on any tick.
  - Non-tick cycles: no state, position or `facing` change.
- **Step attempt in direction d:**
  - The step is refused if the matching `collision` bit is 1.
  - The step is also refused if it would leave the legal range: `pos_h == 0` moving left, `pos_h == H_MAX` moving right, `pos_v == 0` moving up, `pos_v == V_MAX` moving down.
  - A refused step pulses `bump`, leaves the position unchanged and stays in WALK.
  - An accepted step adds or subtracts exactly 1 on the relevant axis and pulses `step`.
- **Arithmetic:** 10-bit unsigned. The boundary checks guarantee the position never wraps.
- **Collision sampling:** `collision` is sampled only on the tick cycle and is the value derived from the pre-step position.

## Timing

- Reset values: `pos_h = H_INIT`, `pos_v = V_INIT`, `facing = DOWN`, `moving = 0`, `step = 0`, `bump = 0`, counter = 0, state IDLE.
- Reset asserted mid-walk returns every register to these values immediately. This is asynchronous and does not wait for a clock edge.
- Latency: the new position is visible on the clock edge that ends the tick cycle. `step` and `bump` are high for exactly the following cycle.
- Keys are sampled only on tick cycles. A key pulse shorter than STEP_DIV cycles that misses every tick is ignored.
- Key release and collision onset in the same tick: release wins. The FSM goes to IDLE and `bump` stays low.
- Maximum speed is one pixel per STEP_DIV cycles.

## Configuration

- `PLAYER_GRID_SNAP_EN` defined:
  - In WALK, the FSM ignores key changes and release while `pos_h % 20 != 0` or `pos_v % 20 != 0`. It keeps stepping in the latched direction until both coordinates are aligned to the 20-pixel tile grid.
  - A refused step also ends the snap, so the player can never deadlock.
  - Arbitration resumes only on aligned ticks.
- `PLAYER_GRID_SNAP_EN` undefined: free pixel-level movement exactly as described in Operation.

## Structure

- Shared package `game_pkg` holds:
  - Direction encodings: UP=2'd0, DOWN=2'd1, LEFT=2'd2, RIGHT=2'd3.
  - Collision bit indices: COL_LEFT=0, COL_RIGHT=1, COL_DOWN=2, COL_UP=3.
  - Constant TILE=20 (sprite/tile size).
- One sub-module, `step_ticker`: the STEP_DIV counter with a `tick` output. Everything else lives in `player_motion`.

## Test plan

All scenarios use STEP_DIV=4.

1. Reset, then no keys for 40 cycles → `pos` stays (300,220), `facing` = DOWN, `moving` = 0, no `step`/`bump` pulses.
2. Hold `key_right` for 5 ticks, `collision` = 0 → `pos_h` = 305, five `step` pulses spaced 4 cycles apart, `moving` = 1; after release, the next tick sets `moving` = 0.
3. Hold `key_left` with `collision` = 4'b0001 → `pos_h` unchanged, `bump` pulses on every tick, `facing` = LEFT.
4. Hold `key_up` and `key_left` together from (300,1) → the first tick gives `pos_v` = 0; later ticks pulse `bump` only, and `pos_h` stays 300.
5. Assert `rst` mid-walk at (310,220) → outputs return asynchronously to (300,220), DOWN, `moving` = 0.
6. With `PLAYER_GRID_SNAP_EN`: tap `key_right` for one tick from (300,220) → `pos_h` reaches 320 after 20 ticks, then the FSM goes IDLE.
